life_keypad: RTL and testbench

//  Button front end for the cursor logic: synchronises and debounces four raw

---
 rtl/life_keypad_if.sv | 20 ++
 rtl/life_keypad.sv | 126 ++++++++++++
 tb/tb_life_keypad.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/life_keypad_if.sv
// Pushbutton-to-cursor signal bundle: raw active-low buttons in, event pulses
// and debounced held levels out.
interface life_keypad_if;
  logic [3:0] btn_n;
  logic       key_down;
  logic       key_up;
  logic       key_left;
  logic       key_right;
  logic [3:0] key_held;

  modport master (
    output btn_n,
    input  key_down, key_up, key_left, key_right, key_held
  );

  modport slave (
    input  btn_n,
    output key_down, key_up, key_left, key_right, key_held
  );
endinterface

// File: rtl/life_keypad.sv
// Button front end: two-flop sync, per-bit debounce, per-key pulse/auto-repeat
// FSM with opposite-key suppression. Bit order [0]down [1]up [2]left [3]right.
module life_keypad #(
  parameter int unsigned DEBOUNCE      = 250000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000,
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned CNT_W         = 25
) (
  input  logic         clk,
  input  logic         reset,
  life_keypad_if.slave kp
);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_e;

  localparam logic [CNT_W-1:0] DB_TERM  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] RD_TERM  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_TERM  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       clean_q;
  logic [3:0]       held_q, held_d;
  logic [3:0]       pulse_q;
  logic [CNT_W-1:0] db_cnt_q  [4];
  logic [CNT_W-1:0] rep_cnt_q [4];
  state_e           state_q   [4];
  logic [3:0]       conflict;

  assign held_d = ~clean_q;

  // Both keys of one axis pressed: that axis goes silent.
  always_comb begin
    conflict    = '0;
    conflict[0] = held_q[0] & held_q[1];
    conflict[1] = held_q[0] & held_q[1];
    conflict[2] = held_q[2] & held_q[3];
    conflict[3] = held_q[2] & held_q[3];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      clean_q <= '1;
      held_q  <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= kp.btn_n;
      sync2_q <= sync1_q;
      held_q  <= held_d;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2_q[i] != clean_q[i]) begin
          if (db_cnt_q[i] == DB_TERM) begin
            clean_q[i]  <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + CNT_ONE;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  // Release or axis conflict overrides any pulse that would fall due this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse_q <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i]   <= IDLE;
        rep_cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        pulse_q[i] <= 1'b0;
        if (!held_q[i] || conflict[i]) begin
          state_q[i]   <= IDLE;
          rep_cnt_q[i] <= '0;
        end else begin
          case (state_q[i])
            IDLE: begin
              pulse_q[i]   <= 1'b1;
              state_q[i]   <= DELAY;
              rep_cnt_q[i] <= '0;
            end
            DELAY: begin
              if (rep_cnt_q[i] == RD_TERM) begin
                rep_cnt_q[i] <= '0;
                if (REPEAT_EN != 0) begin
                  pulse_q[i] <= 1'b1;
                  state_q[i] <= REPEAT;
                end
              end else begin
                rep_cnt_q[i] <= rep_cnt_q[i] + CNT_ONE;
              end
            end
            REPEAT: begin
              if (rep_cnt_q[i] == RP_TERM) begin
                rep_cnt_q[i] <= '0;
                pulse_q[i]   <= 1'b1;
              end else begin
                rep_cnt_q[i] <= rep_cnt_q[i] + CNT_ONE;
              end
            end
            default: begin
              state_q[i]   <= IDLE;
              rep_cnt_q[i] <= '0;
            end
          endcase
        end
      end
    end
  end

  assign kp.key_down  = pulse_q[0];
  assign kp.key_up    = pulse_q[1];
  assign kp.key_left  = pulse_q[2];
  assign kp.key_right = pulse_q[3];
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_life_keypad.sv
// Bench for life_keypad: expected pulse times derived from the latency rules,
// queued at stimulus time and matched against observed pulses.
module tb_life_keypad;
  localparam int DB  = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int LAT = DB + 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  life_keypad_if kp1();
  life_keypad_if kp2();

  life_keypad #(.DEBOUNCE(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                .REPEAT_EN(1), .CNT_W(25))
    dut1 (.clk(clk), .reset(reset), .kp(kp1));

  life_keypad #(.DEBOUNCE(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                .REPEAT_EN(0), .CNT_W(25))
    dut2 (.clk(clk), .reset(reset), .kp(kp2));

  logic [3:0] p1, p2;
  assign p1 = {kp1.key_right, kp1.key_left, kp1.key_up, kp1.key_down};
  assign p2 = {kp2.key_right, kp2.key_left, kp2.key_up, kp2.key_down};

  typedef struct {int key; int cyc;} exp_t;
  typedef struct {logic [3:0] mask; int hold;} vec_t;

  exp_t sbq[$];
  vec_t vecs[10];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   up2_cnt, up2_cyc, other2_cnt;

  task automatic check(input string name, input int got, input int req);
    n_vec++;
    if (got != req) begin
      n_miss++;
      $display("FAIL %s at cyc %0d: got %0d, required %0d", name, cyc, got, req);
    end
  endtask

  // Pulses for keys in mask pressed (sampled) at edge p, none later than last.
  function automatic void push_exp(input logic [3:0] mask, input int p, input int last);
    int   t;
    exp_t e;
    t = p + LAT;
    while (t <= last) begin
      for (int k = 0; k < 4; k++) begin
        if (mask[k]) begin
          e.key = k;
          e.cyc = t;
          sbq.push_back(e);
        end
      end
      t += (t == p + LAT) ? RD : RP;
    end
  endfunction

  task automatic drained(input string name);
    n_vec++;
    if (sbq.size() != 0) begin
      n_miss++;
      $display("FAIL %s: %0d pulses missing, first key=%0d cyc=%0d, required none pending",
               name, sbq.size(), sbq[0].key, sbq[0].cyc);
    end
    sbq.delete();
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (p1[k]) begin
          n_vec++;
          if (sbq.size() == 0) begin
            n_miss++;
            $display("FAIL unexpected_pulse: key=%0d cyc=%0d, required no pulse", k, cyc);
          end else begin
            e = sbq.pop_front();
            if (e.key != k || e.cyc != cyc) begin
              n_miss++;
              $display("FAIL pulse: got key=%0d cyc=%0d, required key=%0d cyc=%0d",
                       k, cyc, e.key, e.cyc);
            end
          end
        end
        if (p2[k]) begin
          if (k == 1) begin
            up2_cnt++;
            up2_cyc = cyc;
          end else begin
            other2_cnt++;
          end
        end
      end
    end
  endtask

  task automatic drive_hold(input logic [3:0] mask, input int hold);
    int p, r;
    logic [3:0] exp_h;
    @(negedge clk);
    p = cyc + 1;
    r = p + hold;
    push_exp(mask, p, (hold >= DB) ? r + LAT - 1 : p - 1);
    kp1.btn_n = ~mask;
    while (cyc < r + 20) begin
      @(negedge clk);
      if (cyc == r - 1) kp1.btn_n = 4'hF;
      exp_h = (hold >= DB && cyc >= p + DB + 2 && cyc <= r + DB + 1) ? mask : 4'h0;
      check("key_held", int'(kp1.key_held), int'(exp_h));
    end
    drained("vector");
  endtask

  task automatic bounce();
    int s;
    @(negedge clk);
    s = cyc + 1 + 20;
    push_exp(4'b0100, s, s + 10 + LAT - 1);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      kp1.btn_n = (((i / 2) % 2) == 0) ? 4'b1011 : 4'hF;
    end
    @(negedge clk);
    kp1.btn_n = 4'b1011;
    repeat (10) @(negedge clk);
    kp1.btn_n = 4'hF;
    repeat (20) @(negedge clk);
    drained("bounce");
  endtask

  task automatic conflict();
    int p, d;
    @(negedge clk);
    p = cyc + 1;
    d = p + 60;
    push_exp(4'b0001, p, p + 36);
    push_exp(4'b0010, d, d + 40 + LAT - 1);
    kp1.btn_n = 4'b1110;
    repeat (30) @(negedge clk);
    kp1.btn_n = 4'b1100;
    repeat (30) @(negedge clk);
    kp1.btn_n = 4'b1101;
    repeat (40) @(negedge clk);
    kp1.btn_n = 4'hF;
    repeat (20) @(negedge clk);
    drained("conflict");
  endtask

  task automatic reset_mid();
    int p, q;
    @(negedge clk);
    p = cyc + 1;
    push_exp(4'b1000, p, p + 29);
    kp1.btn_n = 4'b0111;
    repeat (30) @(negedge clk);
    check("held_before_reset", int'(kp1.key_held), 8);
    #2 reset = 1'b0;
    #1;
    check("reset_async_pulses", int'(p1), 0);
    check("reset_async_held", int'(kp1.key_held), 0);
    repeat (3) @(negedge clk);
    drained("before_reset_release");
    reset = 1'b1;
    q = cyc + 1;
    push_exp(4'b1000, q, q + 40 + LAT - 1);
    repeat (40) @(negedge clk);
    kp1.btn_n = 4'hF;
    repeat (20) @(negedge clk);
    drained("reset_mid");
  endtask

  task automatic repeat_off();
    int p;
    up2_cnt    = 0;
    up2_cyc    = -1;
    other2_cnt = 0;
    @(negedge clk);
    p = cyc + 1;
    kp2.btn_n = 4'b1101;
    repeat (100) @(negedge clk);
    kp2.btn_n = 4'hF;
    repeat (20) @(negedge clk);
    check("rep_off_up_count", up2_cnt, 1);
    check("rep_off_up_cyc", up2_cyc, p + LAT);
    check("rep_off_other", other2_cnt, 0);
  endtask

  initial begin
    vecs[0] = '{4'b0001, 12};
    vecs[1] = '{4'b1000, 60};
    vecs[2] = '{4'b0010, 3};
    vecs[3] = '{4'b0100, 4};
    vecs[4] = '{4'b0010, 29};
    vecs[5] = '{4'b0100, 35};
    vecs[6] = '{4'b0001, 27};
    vecs[7] = '{4'b1000, 21};
    vecs[8] = '{4'b1000, 20};
    vecs[9] = '{4'b0101, 30};

    kp1.btn_n = 4'hF;
    kp2.btn_n = 4'hF;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("reset_pulses1", int'(p1), 0);
    check("reset_held1", int'(kp1.key_held), 0);
    check("reset_pulses2", int'(p2), 0);
    check("reset_held2", int'(kp2.key_held), 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      drive_hold(vecs[v].mask, vecs[v].hold);
    end
    bounce();
    conflict();
    reset_mid();
    repeat_off();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
